decode_issue: RTL and testbench
===============================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage directly upstream of regBank. Splits the fetched instruction, drives the regBank read
//  addresses, captures the operands into an output pipeline register and hands it to execute. A per-register
//  scoreboard stalls RAW hazards against writes still in flight; those writes retire via the regBank write port.
// PARAMETERS
//  DATA_W      32  operand/instruction width
//  REG_ADDR_W  5   register address width (NUM_REGS = 2**REG_ADDR_W)
//  STALL_CNT_W 16  width of saturating hazard-stall counter
// PORTS
//  clk         in   1         single clock, rising edge
//  reset       in   1         asynchronous, active-low; all state cleared while low
//  in_valid    in   1         fetch presents instr
//  in_ready    out  1         decode accepts instr this cycle
//  instr       in   DATA_W    [31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm
//  reg1        out  5         regBank read addr 1 = instr[20:16] (combinational)
//  reg2        out  5         regBank read addr 2 = instr[15:11] (combinational)
//  reg1_data   in   DATA_W    regBank reg1_out (combinational read)
//  reg2_data   in   DATA_W    regBank reg2_out
//  wb_en       in   1         same signal as regBank write_en
//  wb_reg      in   5         same signal as regBank reg_wr
//  out_valid   out  1         issue register holds an instruction
//  out_ready   in   1         execute consumes it
//  out_op      out  6         opcode
//  out_rd      out  5         destination
//  out_wr      out  1         instruction writes rd
//  out_a       out  DATA_W    rs1 operand
//  out_b       out  DATA_W    rs2 operand
//  out_imm     out  DATA_W    sign-extended imm
//  halted      out  1         HALT state reached
//  stall_cnt   out  STALL_CNT_W hazard-stall cycles, saturating
// BEHAVIOUR
//  Reset: out_valid=0, all out_* fields=0, halted=0, stall_cnt=0, scoreboard=0, state=RUN; in_ready=0 while reset low.
//  Op classes: 00 R-ALU (rs1, rs2, writes rd); 01..0F I-ALU (rs1, writes rd); 10 LOAD (rs1, writes rd);
//   11 STORE (rs1, rs2); 20..2F BRANCH (rs1, rs2); 3F HALT (none); anything else = NOP (none).
//  hazard = in_valid & ((uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2])); pend[0] is hardwired 0.
//  in_ready = (state==RUN) & ~hazard & (~out_valid | out_ready).
//  Issue (in_valid & in_ready): at the edge, load the out_* fields from instr/reg1_data/reg2_data; out_valid=1.
//   If writes_rd and rd!=0, set pend[rd]. Latency instr->out_valid = 1 cycle.
//  out_valid & out_ready & no issue -> out_valid=0. Issue while out_ready=1 -> back-to-back, out_valid stays 1.
//  Retire: wb_en & wb_reg!=0 clears pend[wb_reg] at the edge. Operand valid from next cycle (regBank writes
//   on that same edge). A hazard therefore clears no earlier than the cycle after the retire; no bypass.
//  Same-edge set and clear of one register: set wins (newer writer pending).
//  wb_en on a non-pending register: no effect, no error.
//  FSM: RUN -(issue of op 3F)-> HALT. HALT: in_ready=0, halted=1, pending issue reg still drains, retires
//   still clear pend. HALT exits only via reset. The HALT instruction itself is issued as out_wr=0.
//  stall_cnt increments each cycle with hazard & state==RUN; holds at all-ones.
//  out_* fields hold while out_valid & ~out_ready (no change under backpressure).
//  Reset asserted mid-stream: in-flight issue reg and scoreboard discarded immediately; no partial update.
// STRUCTURE
//  Shared package risc_pkg: opcode localparams (OP_RALU, OP_LOAD, OP_STORE, OP_BR_LO/HI, OP_HALT),
//   instruction field bit positions, REG_ADDR_W.
//  One sub-module: decode_scoreboard (pend vector, set/clear ports, two lookup ports).
//   Decode logic, FSM and issue register live in the top level.
// TESTING
//  1 Reset low 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, stall_cnt=0; release -> first instr issues.
//  2 R-ALU rd=5, rs1=1, rs2=2, regBank r1=7, r2=9, out_ready=1 -> next cycle out_a=7, out_b=9, out_rd=5,
//    out_wr=1; pend[5]=1.
//  3 Issue LOAD rd=3, then R-ALU rs1=3: stalls, stall_cnt rises each cycle; wb_en=1, wb_reg=3 at cycle N
//    -> issue at N+1 with out_a = the newly written value.
//  4 Same-edge issue of writer rd=4 and wb_reg=4 retire -> pend[4]=1 afterwards; dependent instr stalls.
//  5 out_ready=0 for 4 cycles with a full issue reg -> in_ready=0, out_* stable; out_ready=1 -> drain, resume.
//  6 Issue HALT (instr=32'hFC000000) -> halted=1, in_ready=0 forever; issue of rd=0 writer never sets pend.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the decode/issue stage: opcode map, instruction field
// positions and the decoded-class record produced from an opcode.
package risc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    localparam logic [5:0] OP_RALU    = 6'h00;
    localparam logic [5:0] OP_IALU_LO = 6'h01;
    localparam logic [5:0] OP_IALU_HI = 6'h0F;
    localparam logic [5:0] OP_LOAD    = 6'h10;
    localparam logic [5:0] OP_STORE   = 6'h11;
    localparam logic [5:0] OP_BR_LO   = 6'h20;
    localparam logic [5:0] OP_BR_HI   = 6'h2F;
    localparam logic [5:0] OP_HALT    = 6'h3F;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic usesRs1;
        logic usesRs2;
        logic writesRd;
        logic isHalt;
    } decode_t;

    // Unlisted opcodes fall through as NOPs: no sources, no destination.
    function automatic decode_t decodeOp(input logic [5:0] op);
        decode_t d;
        d = '0;
        if (op == OP_RALU) begin
            d.usesRs1  = 1'b1;
            d.usesRs2  = 1'b1;
            d.writesRd = 1'b1;
        end else if (op >= OP_IALU_LO && op <= OP_IALU_HI) begin
            d.usesRs1  = 1'b1;
            d.writesRd = 1'b1;
        end else if (op == OP_LOAD) begin
            d.usesRs1  = 1'b1;
            d.writesRd = 1'b1;
        end else if (op == OP_STORE) begin
            d.usesRs1 = 1'b1;
            d.usesRs2 = 1'b1;
        end else if (op >= OP_BR_LO && op <= OP_BR_HI) begin
            d.usesRs1 = 1'b1;
            d.usesRs2 = 1'b1;
        end else if (op == OP_HALT) begin
            d.isHalt = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch, regBank and execute-side signals of the decode/issue stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface decode_issue_if #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      instr;
    logic [REG_ADDR_W-1:0]  reg1;
    logic [REG_ADDR_W-1:0]  reg2;
    logic [DATA_W-1:0]      reg1_data;
    logic [DATA_W-1:0]      reg2_data;
    logic                   wb_en;
    logic [REG_ADDR_W-1:0]  wb_reg;
    logic                   out_valid;
    logic                   out_ready;
    logic [5:0]             out_op;
    logic [REG_ADDR_W-1:0]  out_rd;
    logic                   out_wr;
    logic [DATA_W-1:0]      out_a;
    logic [DATA_W-1:0]      out_b;
    logic [DATA_W-1:0]      out_imm;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, instr, reg1_data, reg2_data, wb_en, wb_reg, out_ready,
        input  in_ready, reg1, reg2, out_valid, out_op, out_rd, out_wr,
               out_a, out_b, out_imm, halted, stall_cnt
    );

    modport slave (
        input  in_valid, instr, reg1_data, reg2_data, wb_en, wb_reg, out_ready,
        output in_ready, reg1, reg2, out_valid, out_op, out_rd, out_wr,
               out_a, out_b, out_imm, halted, stall_cnt
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-write scoreboard: one bit per architectural register,
// set on issue of a writer, cleared when the regBank write retires.
module decode_scoreboard
    import risc_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] look1_addr_i,
    output logic              look1_pend_o,
    input  logic [ADDR_W-1:0] look2_addr_i,
    output logic              look2_pend_o
);

    localparam int NUM = 2 ** ADDR_W;

    logic [NUM-1:0] pend_q;
    logic [NUM-1:0] pend_d;

    // Set is applied after clear so a newer writer stays pending when both
    // hit the same register on one edge; r0 can never be pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign look1_pend_o = pend_q[look1_addr_i];
    assign look2_pend_o = pend_q[look2_addr_i];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits the instruction, reads operands from regBank,
// stalls on RAW hazards via the scoreboard and holds one issue register for execute.
module decode_issue
    import risc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    decode_issue_if.slave  bus
);

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [5:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [IMM_W-1:0]      imm;
    decode_t               dec;

    logic pend1;
    logic pend2;
    logic hazard;
    logic inReady;
    logic issue;

    state_t                 state_q;
    logic                   halted_q;
    logic [STALL_CNT_W-1:0] stallCnt_q;

    logic                  outValid_q, outValid_d;
    logic [5:0]            outOp_q,    outOp_d;
    logic [REG_ADDR_W-1:0] outRd_q,    outRd_d;
    logic                  outWr_q,    outWr_d;
    logic [DATA_W-1:0]     outA_q,     outA_d;
    logic [DATA_W-1:0]     outB_q,     outB_d;
    logic [DATA_W-1:0]     outImm_q,   outImm_d;

    assign op  = bus.instr[OP_MSB:OP_LSB];
    assign rd  = bus.instr[RD_LSB  +: REG_ADDR_W];
    assign rs1 = bus.instr[RS1_LSB +: REG_ADDR_W];
    assign rs2 = bus.instr[RS2_LSB +: REG_ADDR_W];
    assign imm = bus.instr[IMM_LSB +: IMM_W];
    assign dec = decodeOp(op);

    decode_scoreboard #(
        .ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_en_i     (issue & dec.writesRd),
        .set_addr_i   (rd),
        .clr_en_i     (bus.wb_en),
        .clr_addr_i   (bus.wb_reg),
        .look1_addr_i (rs1),
        .look1_pend_o (pend1),
        .look2_addr_i (rs2),
        .look2_pend_o (pend2)
    );

    // No bypass from writeback: a source waits until the cycle after its retire.
    assign hazard  = bus.in_valid & ((dec.usesRs1 & pend1) | (dec.usesRs2 & pend2));
    assign inReady = reset & (state_q == ST_RUN) & ~hazard & (~outValid_q | bus.out_ready);
    assign issue   = bus.in_valid & inReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            halted_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard && (stallCnt_q != '1)) begin
                        stallCnt_q <= stallCnt_q + STALL_ONE;
                    end
                    if (issue && dec.isHalt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Fields only change on a new issue, so they hold steady under backpressure.
    always_comb begin
        outValid_d = outValid_q;
        outOp_d    = outOp_q;
        outRd_d    = outRd_q;
        outWr_d    = outWr_q;
        outA_d     = outA_q;
        outB_d     = outB_q;
        outImm_d   = outImm_q;
        if (issue) begin
            outValid_d = 1'b1;
            outOp_d    = op;
            outRd_d    = rd;
            outWr_d    = dec.writesRd;
            outA_d     = bus.reg1_data;
            outB_d     = bus.reg2_data;
            outImm_d   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid_q <= 1'b0;
            outOp_q    <= '0;
            outRd_q    <= '0;
            outWr_q    <= 1'b0;
            outA_q     <= '0;
            outB_q     <= '0;
            outImm_q   <= '0;
        end else begin
            outValid_q <= outValid_d;
            outOp_q    <= outOp_d;
            outRd_q    <= outRd_d;
            outWr_q    <= outWr_d;
            outA_q     <= outA_d;
            outB_q     <= outB_d;
            outImm_q   <= outImm_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.reg1      = rs1;
    assign bus.reg2      = rs2;
    assign bus.out_valid = outValid_q;
    assign bus.out_op    = outOp_q;
    assign bus.out_rd    = outRd_q;
    assign bus.out_wr    = outWr_q;
    assign bus.out_a     = outA_q;
    assign bus.out_b     = outB_q;
    assign bus.out_imm   = outImm_q;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the stage and a regBank array.
module tb_decode_issue;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    decode_issue_if #(.DATA_W(32), .REG_ADDR_W(5), .STALL_CNT_W(16)) bus ();

    decode_issue #(.DATA_W(32), .REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] regFile [32];
    assign bus.reg1_data = regFile[bus.reg1];
    assign bus.reg2_data = regFile[bus.reg2];

    int testsRun = 0;
    int testsFailed = 0;

    bit          mPend [32];
    bit          mHalted;
    bit          mValid;
    bit          mIssued;
    logic [5:0]  mOp;
    logic [4:0]  mRd;
    bit          mWr;
    logic [31:0] mA;
    logic [31:0] mB;
    logic [31:0] mImm;
    int          mStall;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [10:0] lo);
        return {op, rd, rs1, rs2, lo};
    endfunction

    // Opcode classes straight from the instruction-set table.
    task automatic classify(input logic [5:0] op, output bit u1, output bit u2,
                            output bit wr, output bit hlt);
        u1 = 0; u2 = 0; wr = 0; hlt = 0;
        if (op == 6'h00) begin
            u1 = 1; u2 = 1; wr = 1;
        end else if (op <= 6'h0F) begin
            u1 = 1; wr = 1;
        end else if (op == 6'h10) begin
            u1 = 1; wr = 1;
        end else if (op == 6'h11) begin
            u1 = 1; u2 = 1;
        end else if (op >= 6'h20 && op <= 6'h2F) begin
            u1 = 1; u2 = 1;
        end else if (op == 6'h3F) begin
            hlt = 1;
        end
    endtask

    task automatic resetModel();
        for (int r = 0; r < 32; r++) mPend[r] = 0;
        mHalted = 0; mValid = 0; mIssued = 0;
        mOp = '0; mRd = '0; mWr = 0; mA = '0; mB = '0; mImm = '0;
        mStall = 0;
    endtask

    function automatic logic [31:0] randInstr();
        int sel;
        logic [5:0] op;
        sel = int'($urandom_range(0, 9));
        case (sel)
            3, 4:    op = 6'($urandom_range(1, 15));
            5:       op = 6'h10;
            6:       op = 6'h11;
            7:       op = 6'($urandom_range(32, 47));
            8:       op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(18, 31))
                                                      : 6'($urandom_range(48, 62));
            default: op = 6'h00;
        endcase
        return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 11'($urandom));
    endfunction

    // One clock: drive at negedge, check handshake before the edge, advance the
    // model across the edge, then check the registered outputs.
    task automatic applyStimulus(input bit inV, input logic [31:0] ins, input bit oR,
                                 input bit wE, input logic [4:0] wR, input logic [31:0] wD);
        bit u1, u2, wr, hlt, haz, expReady, issue;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] nA, nB, nImm;
        int nStall;
        @(negedge clk);
        bus.in_valid  = inV;
        bus.instr     = ins;
        bus.out_ready = oR;
        bus.wb_en     = wE;
        bus.wb_reg    = wR;
        #1;
        classify(ins[31:26], u1, u2, wr, hlt);
        rd = ins[25:21]; rs1 = ins[20:16]; rs2 = ins[15:11];
        haz = inV && ((u1 && rs1 != 0 && mPend[rs1]) || (u2 && rs2 != 0 && mPend[rs2]));
        expReady = !mHalted && !haz && (!mValid || oR);
        issue = inV && expReady;
        checkOutput("in_ready", bus.in_ready, expReady);
        checkOutput("reg1", bus.reg1, rs1);
        checkOutput("reg2", bus.reg2, rs2);
        nStall = (!mHalted && haz && mStall < 65535) ? mStall + 1 : mStall;
        nA = regFile[rs1];
        nB = regFile[rs2];
        nImm = 32'(signed'(ins[15:0]));
        @(posedge clk);
        #1;
        if (wE && wR != 0) begin
            regFile[wR] = wD;
            mPend[wR] = 0;
        end
        if (issue) begin
            if (wr && rd != 0) mPend[rd] = 1;
            mValid = 1; mOp = ins[31:26]; mRd = rd; mWr = wr;
            mA = nA; mB = nB; mImm = nImm;
            if (hlt) mHalted = 1;
        end else if (oR) begin
            mValid = 0;
        end
        mStall = nStall;
        mIssued = issue;
        checkOutput("out_valid", bus.out_valid, mValid);
        checkOutput("out_op", bus.out_op, mOp);
        checkOutput("out_rd", bus.out_rd, mRd);
        checkOutput("out_wr", bus.out_wr, mWr);
        checkOutput("out_a", bus.out_a, mA);
        checkOutput("out_b", bus.out_b, mB);
        checkOutput("out_imm", bus.out_imm, mImm);
        checkOutput("halted", bus.halted, mHalted);
        checkOutput("stall_cnt", bus.stall_cnt, mStall);
    endtask

    initial begin
        logic [31:0] curInstr;
        bit curValid;
        bit oR, wE;
        logic [4:0] wR;
        int cands[$];

        for (int r = 0; r < 32; r++) regFile[r] = $urandom;
        regFile[0] = 32'h0; regFile[1] = 32'd7; regFile[2] = 32'd9;
        resetModel();

        // Reset held with a valid instruction waiting upstream.
        bus.in_valid = 1; bus.instr = mk(6'h00, 5, 1, 2, 0);
        bus.out_ready = 1; bus.wb_en = 0; bus.wb_reg = 0;
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checkOutput("rst_in_ready", bus.in_ready, 0);
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_stall_cnt", bus.stall_cnt, 0);
        end
        bus.in_valid = 0;
        reset = 1;

        // R-ALU rd5 = r1 op r2, then a dependent that waits for r5 to retire.
        applyStimulus(1, mk(6'h00, 5, 1, 2, 11'h010), 1, 0, 0, 0);
        checkOutput("t1_first_issue", bus.out_valid, 1);
        checkOutput("t2_out_a", bus.out_a, 32'd7);
        checkOutput("t2_out_b", bus.out_b, 32'd9);
        checkOutput("t2_out_rd", bus.out_rd, 5);
        checkOutput("t2_out_wr", bus.out_wr, 1);
        applyStimulus(1, mk(6'h01, 6, 5, 0, 0), 1, 0, 0, 0);
        checkOutput("t2_pend5_stall", bus.in_ready, 0);
        applyStimulus(1, mk(6'h01, 6, 5, 0, 0), 1, 1, 5, 32'h55);
        applyStimulus(1, mk(6'h01, 6, 5, 0, 0), 1, 0, 0, 0);
        checkOutput("t2_after_retire_a", bus.out_a, 32'h55);

        // LOAD r3 then a consumer of r3: stalls until the retire, operand is the new value.
        applyStimulus(1, mk(6'h10, 3, 0, 0, 0), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, mk(6'h00, 6, 3, 0, 0), 1, 0, 0, 0);
        applyStimulus(1, mk(6'h00, 6, 3, 0, 0), 1, 1, 3, 32'hABCD);
        applyStimulus(1, mk(6'h00, 6, 3, 0, 0), 1, 0, 0, 0);
        checkOutput("t3_out_a", bus.out_a, 32'hABCD);
        checkOutput("t3_stall_cnt", bus.stall_cnt, 6);

        // Writer of r4 issued on the same edge r4 retires: r4 must remain pending.
        applyStimulus(1, mk(6'h00, 4, 0, 0, 0), 1, 1, 4, 32'h44);
        applyStimulus(1, mk(6'h01, 7, 4, 0, 5), 1, 0, 0, 0);
        checkOutput("t4_set_wins", bus.in_ready, 0);
        applyStimulus(1, mk(6'h01, 7, 4, 0, 5), 1, 1, 4, 32'h99);
        applyStimulus(1, mk(6'h01, 7, 4, 0, 5), 1, 0, 0, 0);
        checkOutput("t4_out_a", bus.out_a, 32'h99);

        // A writer of r0 never makes r0 pending.
        applyStimulus(1, mk(6'h00, 0, 1, 2, 0), 1, 0, 0, 0);
        applyStimulus(1, mk(6'h01, 10, 0, 0, 0), 1, 0, 0, 0);
        checkOutput("t6_r0_no_pend", bus.out_rd, 10);

        // Backpressure: full issue register with execute stalled for four cycles.
        applyStimulus(1, mk(6'h00, 8, 1, 2, 11'h123), 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, mk(6'h00, 9, 1, 2, 0), 0, 0, 0, 0);
        checkOutput("t5_hold_a", bus.out_a, 32'd7);
        checkOutput("t5_hold_b", bus.out_b, 32'd9);
        checkOutput("t5_hold_rd", bus.out_rd, 8);
        checkOutput("t5_hold_imm", bus.out_imm, 32'h00001123);
        applyStimulus(1, mk(6'h00, 9, 1, 2, 0), 1, 0, 0, 0);
        checkOutput("t5_resume_rd", bus.out_rd, 9);

        // Randomized traffic; fetch holds an instruction until it is accepted.
        curValid = 0;
        curInstr = '0;
        for (int c = 0; c < 1500; c++) begin
            if (mIssued || !curValid) begin
                curValid = ($urandom_range(0, 7) != 0);
                curInstr = randInstr();
            end
            oR = ($urandom_range(0, 3) != 0);
            wE = 0;
            wR = '0;
            if ($urandom_range(0, 2) == 0) begin
                wE = 1;
                cands.delete();
                for (int r = 1; r < 32; r++) if (mPend[r]) cands.push_back(r);
                if (cands.size() > 0) wR = 5'(cands[$urandom_range(0, cands.size() - 1)]);
                else wR = 5'($urandom_range(0, 7));
            end
            applyStimulus(curValid, curInstr, oR, wE, wR, $urandom);
        end

        // Asynchronous reset in the middle of a cycle with state in flight.
        applyStimulus(1, mk(6'h00, 10, 0, 0, 0), 1, 0, 0, 0);
        @(negedge clk); #2;
        reset = 0;
        #1;
        checkOutput("mid_rst_out_valid", bus.out_valid, 0);
        checkOutput("mid_rst_stall_cnt", bus.stall_cnt, 0);
        checkOutput("mid_rst_in_ready", bus.in_ready, 0);
        resetModel();
        repeat (2) @(negedge clk);
        bus.in_valid = 0; bus.wb_en = 0;
        reset = 1;
        applyStimulus(1, mk(6'h01, 11, 10, 0, 0), 1, 0, 0, 0);
        checkOutput("mid_rst_pend_clear", bus.out_rd, 11);

        // HALT with a write to r9 still outstanding; retire continues afterwards.
        applyStimulus(1, mk(6'h00, 9, 0, 0, 0), 1, 0, 0, 0);
        applyStimulus(1, 32'hFC000000, 1, 0, 0, 0);
        checkOutput("t6_halted", bus.halted, 1);
        checkOutput("t6_halt_wr", bus.out_wr, 0);
        checkOutput("t6_halt_op", bus.out_op, 6'h3F);
        for (int i = 0; i < 6; i++)
            applyStimulus(1, randInstr(), 1, (i == 2), 5'd9, 32'h1234);
        checkOutput("t6_in_ready", bus.in_ready, 0);
        checkOutput("t6_drained", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
